// File: rtl/otp_pkg.sv
// Shared level encodings and write-FSM states
// for the OTP bit-cell array model.
package otp_pkg;

   localparam logic       BL_GND      = 1'b0;
   localparam logic       BL_MID      = 1'b1;

   localparam logic [1:0] PL_GND      = 2'b00;
   localparam logic [1:0] PL_MID      = 2'b01;
   localparam logic [1:0] PL_READ     = 2'b10;
   localparam logic [1:0] PL_HIGH     = 2'b11;

   localparam logic       WLN_MID     = 1'b0;
   localparam logic       WLN_GND     = 1'b1;

   localparam logic       WLP_HIGH    = 1'b0;
   localparam logic       WLP_MID     = 1'b1;

   localparam logic       PRG_READING = 1'b0;
   localparam logic       PRG_WRITING = 1'b1;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_PROG,
      WR_DONE
   } wr_state_t;

endpackage

// File: rtl/otp_fuse_cell.sv
// One OTP cell: consecutive-bias counter plus fuse.
// blown_nxt exposes the fuse value after this edge.
module otp_fuse_cell #(
   parameter int PROG_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic prog_bias,
   output logic blown,
   output logic blown_nxt
);

   localparam int CW = $clog2(PROG_CYCLES + 1);
   localparam logic [CW-1:0] CMAX  = CW'(PROG_CYCLES);
   localparam logic [CW-1:0] CLAST = CW'(PROG_CYCLES - 1);

   logic [CW-1:0] cnt;

   // the fuse blows on the edge that completes the run
   assign blown_nxt = blown | (prog_bias && (cnt >= CLAST));

   // count consecutive biased cycles, saturating; fuse is sticky
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         blown <= 1'b0;
      end else begin
         blown <= blown_nxt;
         if (!prog_bias)
            cnt <= '0;
         else if (cnt != CMAX)
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/otp_array_model.sv
// Behavioural responder for the OTP array: bias decode,
// fuse cells, write-verify FSM, sense pipeline, fault flag.
module otp_array_model
   import otp_pkg::*;
#(
   parameter int A           = 2,
   parameter int B           = 2,
   parameter int PROG_CYCLES = 4,
   parameter int SENSE_LAT   = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [2*B-1:0] PL,
   input  logic [B-1:0]   BL,
   input  logic [A-1:0]   WLN,
   input  logic [A-1:0]   WLP,
   input  logic           PRG,
   input  logic           read_active,
   output logic           writing_successful,
   output logic           output_read_circuit,
   output logic           fault
);

   logic [A*B-1:0]       pb;
   logic [A*B-1:0]       rs;
   logic [A*B-1:0]       fz;
   logic [A*B-1:0]       fz_nxt;
   logic [A-1:0]         row_pb;
   logic                 any_pb;
   logic                 pend;
   logic                 sense_in;
   logic                 bad;
   logic [SENSE_LAT-1:0] pipe;
   wr_state_t            state;

   // per-cell program and read selection, flat index i*B+j
   always_comb begin
      pb     = '0;
      rs     = '0;
      row_pb = '0;
      for (int i = 0; i < A; i++) begin
         for (int j = 0; j < B; j++) begin
            pb[i*B+j] = (PRG == PRG_WRITING)
                     && (WLP[i] == WLP_HIGH)
                     && (WLN[i] == WLN_MID)
                     && (BL[j] == BL_GND)
                     && (PL[j*2+:2] == PL_HIGH);
            rs[i*B+j] = (PRG == PRG_READING)
                     && read_active
                     && (WLP[i] == WLP_MID)
                     && (WLN[i] == WLN_MID)
                     && (BL[j] == BL_GND)
                     && (PL[j*2+:2] == PL_READ);
         end
         row_pb[i] = |pb[i*B+:B];
      end
   end

   assign any_pb   = |pb;
   assign pend     = |(pb & ~fz_nxt);
   assign sense_in = ($countones(rs) == 1) && (|(rs & fz));
   assign bad      = ($countones(row_pb) > 1)
                  || ($countones(rs) > 1)
                  || ((PRG == PRG_WRITING) && read_active);

   for (genvar g = 0; g < A*B; g++) begin : g_cell
      otp_fuse_cell #(
         .PROG_CYCLES (PROG_CYCLES)
      ) u_cell (
         .clk       (clk),
         .reset     (reset),
         .prog_bias (pb[g]),
         .blown     (fz[g]),
         .blown_nxt (fz_nxt[g])
      );
   end

   // write-verify FSM; DONE is judged on post-edge fuse values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= WR_IDLE;
         writing_successful <= 1'b0;
      end else begin
         unique case (state)
            WR_IDLE: begin
               if (any_pb)
                  state <= WR_PROG;
            end
            WR_PROG: begin
               if (PRG == PRG_READING) begin
                  state <= WR_IDLE;
               end else if (any_pb && !pend) begin
                  state              <= WR_DONE;
                  writing_successful <= 1'b1;
               end
            end
            WR_DONE: begin
               if (PRG == PRG_READING) begin
                  state              <= WR_IDLE;
                  writing_successful <= 1'b0;
               end else if (pend) begin
                  state              <= WR_PROG;
                  writing_successful <= 1'b0;
               end
            end
            default: begin
               state              <= WR_IDLE;
               writing_successful <= 1'b0;
            end
         endcase
      end
   end

   // fixed-latency sense pipeline; tail drives the read output
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pipe <= '0;
      else
         pipe <= (pipe << 1) | SENSE_LAT'(sense_in);
   end

   assign output_read_circuit = pipe[SENSE_LAT-1];

   // sticky illegal-bias flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fault <= 1'b0;
      else if (bad)
         fault <= 1'b1;
   end

endmodule

// File: tb/tb_otp_array_model.sv
// Self-checking bench for otp_array_model: directed
// scenarios then randomized bias against a reference model.
module tb_otp_array_model;

   localparam int A  = 2;
   localparam int B  = 2;
   localparam int PC = 4;
   localparam int SL = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   PL;
   logic [1:0]   BL;
   logic [1:0]   WLN;
   logic [1:0]   WLP;
   logic         PRG;
   logic         read_active;
   logic         writing_successful;
   logic         output_read_circuit;
   logic         fault;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int run [A][B];
   bit fz  [A][B];
   int st;
   bit pm  [SL];
   bit flt;

   otp_array_model #(
      .A           (A),
      .B           (B),
      .PROG_CYCLES (PC),
      .SENSE_LAT   (SL)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .PL                  (PL),
      .BL                  (BL),
      .WLN                 (WLN),
      .WLP                 (WLP),
      .PRG                 (PRG),
      .read_active         (read_active),
      .writing_successful  (writing_successful),
      .output_read_circuit (output_read_circuit),
      .fault               (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs,
                      input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < A; i++)
         for (int j = 0; j < B; j++) begin
            run[i][j] = 0;
            fz[i][j]  = 0;
         end
      for (int k = 0; k < SL; k++) pm[k] = 0;
      st  = 0;
      flt = 0;
   endtask

   // one clock edge of the array, from the bias rules
   task automatic model_edge();
      bit pb [A][B];
      bit rs [A][B];
      int nrow = 0;
      int nrs  = 0;
      bit sensed = 0;
      bit anyb = 0;
      bit pend = 0;
      for (int i = 0; i < A; i++) begin
         bit rowb = 0;
         for (int j = 0; j < B; j++) begin
            pb[i][j] = PRG && WLP[i] == 1'b0 && WLN[i] == 1'b0
                    && BL[j] == 1'b0 && PL[j*2+:2] == 2'b11;
            rs[i][j] = !PRG && read_active && WLP[i] == 1'b1
                    && WLN[i] == 1'b0 && BL[j] == 1'b0
                    && PL[j*2+:2] == 2'b10;
            if (pb[i][j]) rowb = 1;
            if (rs[i][j]) begin
               nrs++;
               sensed = fz[i][j];
            end
         end
         if (rowb) nrow++;
      end
      if (nrs != 1) sensed = 0;
      if (nrow > 1 || nrs > 1 || (PRG && read_active)) flt = 1;
      for (int i = 0; i < A; i++)
         for (int j = 0; j < B; j++) begin
            run[i][j] = pb[i][j] ? run[i][j] + 1 : 0;
            if (run[i][j] >= PC) fz[i][j] = 1;
            if (pb[i][j]) begin
               anyb = 1;
               if (!fz[i][j]) pend = 1;
            end
         end
      case (st)
         0: if (anyb) st = 1;
         1: if (!PRG) st = 0; else if (anyb && !pend) st = 2;
         default: if (!PRG) st = 0; else if (pend) st = 1;
      endcase
      for (int k = SL - 1; k > 0; k--) pm[k] = pm[k-1];
      pm[0] = sensed;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("ws", writing_successful, st == 2);
      chk("orc", output_read_circuit, pm[SL-1]);
      chk("fault", fault, flt);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      model_clear();
      chk("rst_ws", writing_successful, 1'b0);
      chk("rst_orc", output_read_circuit, 1'b0);
      chk("rst_fault", fault, 1'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_idle();
      PRG = 1'b0; read_active = 1'b0;
      WLP = 2'b11; WLN = 2'b11; BL = 2'b11; PL = 4'b0000;
   endtask

   task automatic set_prog(input int i, input int j);
      PRG = 1'b1; read_active = 1'b0;
      WLP = 2'b11; WLP[i] = 1'b0;
      WLN = 2'b11; WLN[i] = 1'b0;
      BL  = 2'b11; BL[j]  = 1'b0;
      PL  = 4'b0101; PL[j*2+:2] = 2'b11;
   endtask

   task automatic set_read(input int i, input int j);
      PRG = 1'b0; read_active = 1'b1;
      WLP = 2'b11;
      WLN = 2'b11; WLN[i] = 1'b0;
      BL  = 2'b11; BL[j]  = 1'b0;
      PL  = 4'b0000; PL[j*2+:2] = 2'b10;
   endtask

   // read cell, return sensed bit after SL edges
   task automatic read_cell(input int i, input int j,
                            input string tag, input logic exp);
      set_read(i, j);
      step();
      set_idle();
      steps(SL - 1);
      chk(tag, output_read_circuit, exp);
      step();
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      model_clear();
      #12;
      do_reset();

      // program (1,0) for 4 cycles
      set_prog(1, 0);
      steps(3);
      chk("ws_before_4th", writing_successful, 1'b0);
      step();
      chk("ws_after_4th", writing_successful, 1'b1);
      set_idle();
      step();
      read_cell(1, 0, "read_10_blown", 1'b1);

      // bias on an already blown cell
      set_prog(1, 0);
      steps(2);
      chk("ws_reblown", writing_successful, 1'b1);
      set_idle();
      step();

      // broken run: 3, gap, 3
      do_reset();
      set_prog(1, 0);
      steps(3);
      set_idle();
      step();
      set_prog(1, 0);
      steps(3);
      chk("ws_broken_run", writing_successful, 1'b0);
      set_idle();
      step();
      read_cell(1, 0, "read_10_unblown", 1'b0);

      // read (0,1) before and after programming
      read_cell(0, 1, "read_01_fresh", 1'b0);
      set_prog(0, 1);
      steps(4);
      set_idle();
      step();
      read_cell(0, 1, "read_01_blown", 1'b1);

      // both rows program-biased
      PRG = 1'b1; read_active = 1'b0;
      WLP = 2'b00; WLN = 2'b00; BL = 2'b10; PL = 4'b0111;
      step();
      chk("fault_two_rows", fault, 1'b1);
      set_idle();
      steps(3);
      chk("fault_sticky", fault, 1'b1);
      do_reset();

      // reset mid-program
      set_prog(1, 1);
      steps(2);
      reset = 1'b1;
      #1;
      chk("mid_ws", writing_successful, 1'b0);
      chk("mid_fault", fault, 1'b0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      set_idle();
      step();
      read_cell(1, 1, "read_11_after_rst", 1'b0);

      // read strobe while writing
      set_read(0, 1);
      PRG = 1'b1;
      steps(SL + 1);
      chk("fault_prg_read", fault, 1'b1);
      chk("orc_prg_read", output_read_circuit, 1'b0);
      set_idle();

      // randomized bias sequences
      do_reset();
      for (int b = 0; b < 150; b++) begin
         int kind = $urandom_range(0, 9);
         int len  = $urandom_range(1, 6);
         int ci   = $urandom_range(0, A - 1);
         int cj   = $urandom_range(0, B - 1);
         if (b % 20 == 19) do_reset();
         for (int k = 0; k < len; k++) begin
            if (kind == 0) begin
               PRG = 1'($urandom); read_active = 1'($urandom);
               WLP = 2'($urandom); WLN = 2'($urandom);
               BL  = 2'($urandom); PL  = 4'($urandom);
            end else if (kind <= 4) begin
               set_prog(ci, cj);
            end else if (kind <= 7) begin
               set_read(ci, cj);
            end else begin
               set_idle();
            end
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
